// File: rtl/vga_line_sched.sv
// Line scheduler for the vga_double scan doubler: locks to the TV line rate and
// emits one page swap / scan-in per TV line, two scan-outs and two VGA hsyncs per TV line.
module vga_line_sched #(
    parameter int unsigned LINE_LEN    = 1792,
    parameter int unsigned CW          = 11,
    parameter int unsigned HS_LEN      = 106,
    parameter int unsigned SCANIN_POS  = 300,
    parameter int unsigned SCANOUT_POS = 150,
    parameter int unsigned LOCK_LINES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tv_line_start,
    output logic swap_start,
    output logic scanin_start,
    output logic scanout_start,
    output logic vga_hs,
    output logic locked
);

    localparam int unsigned HALF = LINE_LEN / 2;
    localparam int unsigned GW   = $clog2(LOCK_LINES + 1);

    localparam logic [CW-1:0] LAST_POS  = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] HALF_POS  = CW'(HALF);
    localparam logic [CW-1:0] HS_END    = CW'(HS_LEN);
    localparam logic [CW-1:0] SCANIN_P  = CW'(SCANIN_POS);
    localparam logic [CW-1:0] SCANOUT_A = CW'(SCANOUT_POS);
    localparam logic [CW-1:0] SCANOUT_B = CW'(HALF + SCANOUT_POS);
    localparam logic [GW-1:0] LOCK_CNT  = GW'(LOCK_LINES);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          swap_q, swap_d;
    logic          scanin_q, scanin_d;
    logic          scanout_q, scanout_d;
    logic          hs_q, hs_d;
    logic          locked_q, locked_d;

    logic          at_end;
    logic          on_time;
    logic          bad_phase;
    logic [CW-1:0] half_pos;

    // Line counter, lock FSM and registered output decodes of the current lcnt/state.
    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        lcnt_d    = lcnt_q + CW'(1);
        half_pos  = lcnt_q;
        at_end    = (lcnt_q == LAST_POS);
        // A pulse is on time only when it lands on the last count of a line;
        // any other pulse, or reaching the line end without one, breaks the run.
        on_time   = tv_line_start && at_end;
        bad_phase = (tv_line_start && !at_end) || (!tv_line_start && at_end);

        if (tv_line_start || at_end) begin
            lcnt_d = '0;
        end

        case (state_q)
            SEARCH: begin
                if (on_time) begin
                    if (gcnt_q + GW'(1) == LOCK_CNT) begin
                        state_d = LOCKED;
                        gcnt_d  = '0;
                    end else begin
                        gcnt_d = gcnt_q + GW'(1);
                    end
                end else if (bad_phase) begin
                    gcnt_d = '0;
                end
            end
            LOCKED: begin
                if (bad_phase) begin
                    state_d = SEARCH;
                    gcnt_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                gcnt_d  = '0;
            end
        endcase

        // Position within the current VGA half line.
        if (lcnt_q >= HALF_POS) begin
            half_pos = lcnt_q - HALF_POS;
        end

        swap_d    = (lcnt_q == '0);
        hs_d      = (half_pos < HS_END);
        scanin_d  = (lcnt_q == SCANIN_P) && (state_q == LOCKED);
        scanout_d = ((lcnt_q == SCANOUT_A) || (lcnt_q == SCANOUT_B)) && (state_q == LOCKED);
        locked_d  = (state_q == LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            lcnt_q    <= '0;
            gcnt_q    <= '0;
            swap_q    <= 1'b0;
            scanin_q  <= 1'b0;
            scanout_q <= 1'b0;
            hs_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lcnt_q    <= lcnt_d;
            gcnt_q    <= gcnt_d;
            swap_q    <= swap_d;
            scanin_q  <= scanin_d;
            scanout_q <= scanout_d;
            hs_q      <= hs_d;
            locked_q  <= locked_d;
        end
    end

    assign swap_start    = swap_q;
    assign scanin_start  = scanin_q;
    assign scanout_start = scanout_q;
    assign vga_hs        = hs_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_vga_line_sched.sv
// Directed bench for vga_line_sched with default parameters.
module tb_vga_line_sched;

    logic clk;
    logic rst;
    logic tv_line_start;
    logic swap_start;
    logic scanin_start;
    logic scanout_start;
    logic vga_hs;
    logic locked;

    int checks = 0;
    int errors = 0;

    // Cumulative output statistics, written only by the monitor.
    int cyc = 0;
    int n_swap = 0;
    int n_scanin = 0;
    int n_scanout = 0;
    int n_hs = 0;
    int n_locked = 0;
    int last_swap = 0;
    int swap_period = 0;

    // Snapshots, written only by the stimulus block.
    int s_swap, s_scanin, s_scanout, s_hs, s_locked;

    vga_line_sched dut (
        .clk           (clk),
        .rst           (rst),
        .tv_line_start (tv_line_start),
        .swap_start    (swap_start),
        .scanin_start  (scanin_start),
        .scanout_start (scanout_start),
        .vga_hs        (vga_hs),
        .locked        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulate output activity 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (swap_start) begin
            swap_period = cyc - last_swap;
            last_swap   = cyc;
            n_swap      = n_swap + 1;
        end
        if (scanin_start)  n_scanin  = n_scanin + 1;
        if (scanout_start) n_scanout = n_scanout + 1;
        if (vga_hs)        n_hs      = n_hs + 1;
        if (locked)        n_locked  = n_locked + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic p);
        tv_line_start = p;
        @(posedge clk);
        #2;
        tv_line_start = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick(1'b0);
    endtask

    // One line of len cycles starting from lcnt=0, pulse (or not) in the last cycle.
    task automatic run_line(input int len, input logic p);
        tick_n(len - 1);
        tick(p);
    endtask

    task automatic snap();
        s_swap    = n_swap;
        s_scanin  = n_scanin;
        s_scanout = n_scanout;
        s_hs      = n_hs;
        s_locked  = n_locked;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_swap"},    int'(swap_start),    0);
        check({tag, "_scanin"},  int'(scanin_start),  0);
        check({tag, "_scanout"}, int'(scanout_start), 0);
        check({tag, "_hs"},      int'(vga_hs),        0);
        check({tag, "_locked"},  int'(locked),        0);
    endtask

    initial begin
        rst           = 1'b1;
        tv_line_start = 1'b0;

        // Reset state
        tick_n(3);
        check_all_zero("reset");
        rst = 1'b0;
        snap();

        // Acquire lock with four on-time lines
        tick(1'b0);
        check("first_swap", int'(swap_start), 1);
        check("first_hs", int'(vga_hs), 1);
        check("first_locked", int'(locked), 0);
        tick_n(1790);
        tick(1'b1);
        repeat (3) run_line(1792, 1'b1);
        check("acq_swaps", n_swap - s_swap, 4);
        check("acq_scanin", n_scanin - s_scanin, 0);
        check("acq_scanout", n_scanout - s_scanout, 0);
        check("acq_hs", n_hs - s_hs, 848);
        check("acq_locked_cycles", n_locked - s_locked, 0);
        check("acq_locked_at_pulse", int'(locked), 0);

        // Locked line, cycle-exact strobe positions (k = edges into line, decode lcnt = k-1)
        snap();
        tick(1'b0);
        check("lk_swap_k1", int'(swap_start), 1);
        check("lk_locked_k1", int'(locked), 1);
        tick_n(105);
        check("lk_hs_k106", int'(vga_hs), 1);
        check("lk_swap_k106", int'(swap_start), 0);
        tick(1'b0);
        check("lk_hs_k107", int'(vga_hs), 0);
        tick_n(44);
        check("lk_scanout_k151", int'(scanout_start), 1);
        tick(1'b0);
        check("lk_scanout_k152", int'(scanout_start), 0);
        tick_n(149);
        check("lk_scanin_k301", int'(scanin_start), 1);
        tick_n(595);
        check("lk_hs_k896", int'(vga_hs), 0);
        tick(1'b0);
        check("lk_hs_k897", int'(vga_hs), 1);
        tick_n(150);
        check("lk_scanout_k1047", int'(scanout_start), 1);
        tick_n(744);
        tick(1'b1);
        check("lk_line_scanin", n_scanin - s_scanin, 1);
        check("lk_line_scanout", n_scanout - s_scanout, 2);
        check("lk_line_hs", n_hs - s_hs, 212);

        // Missing pulse: lock drops, four on-time lines restore it
        snap();
        run_line(1792, 1'b0);
        check("miss_locked_end", int'(locked), 1);
        tick(1'b0);
        check("miss_locked_drop", int'(locked), 0);
        check("miss_swap_wrap", int'(swap_start), 1);
        tick_n(1790);
        tick(1'b1);
        repeat (3) run_line(1792, 1'b1);
        check("miss_swaps", n_swap - s_swap, 5);
        check("miss_period", swap_period, 1792);
        check("miss_scanin", n_scanin - s_scanin, 1);
        check("miss_scanout", n_scanout - s_scanout, 2);
        check("miss_locked_cycles", n_locked - s_locked, 1792);
        check("miss_locked_pre", int'(locked), 0);
        tick(1'b0);
        check("miss_relocked", int'(locked), 1);

        // Early pulse at lcnt=1000 truncates the line and drops lock
        snap();
        tick_n(999);
        tick(1'b1);
        check("early_scanin", n_scanin - s_scanin, 1);
        check("early_scanout", n_scanout - s_scanout, 1);
        check("early_swaps", n_swap - s_swap, 0);
        tick(1'b0);
        check("early_swap_new", int'(swap_start), 1);
        check("early_locked", int'(locked), 0);
        snap();
        tick_n(1790);
        tick(1'b1);
        repeat (3) run_line(1792, 1'b1);
        check("early_relock_locked", n_locked - s_locked, 0);
        check("early_relock_scanin", n_scanin - s_scanin, 0);
        check("early_relock_scanout", n_scanout - s_scanout, 0);
        tick(1'b0);
        check("early_relocked", int'(locked), 1);

        // Reset mid-line at lcnt=500 together with a pulse
        tick_n(499);
        rst = 1'b1;
        tick(1'b1);
        check_all_zero("midrst");
        rst = 1'b0;
        snap();
        tick(1'b0);
        check("midrst_swap", int'(swap_start), 1);
        check("midrst_locked", int'(locked), 0);
        tick_n(1790);
        tick(1'b1);
        check("midrst_scanin", n_scanin - s_scanin, 0);
        check("midrst_scanout", n_scanout - s_scanout, 0);
        check("midrst_locked_cycles", n_locked - s_locked, 0);

        // Late pulses (period 1793): never on time, swap pairs 1 clk apart
        snap();
        run_line(1793, 1'b1);
        check("late_swap_wrap", int'(swap_start), 1);
        check("late_period_wrap", swap_period, 1792);
        tick(1'b0);
        check("late_swap_pair", int'(swap_start), 1);
        check("late_period_pair", swap_period, 1);
        tick(1'b0);
        check("late_swap_after", int'(swap_start), 0);
        tick_n(1790);
        tick(1'b1);
        repeat (2) run_line(1793, 1'b1);
        check("late_swaps", n_swap - s_swap, 8);
        check("late_locked_cycles", n_locked - s_locked, 0);
        check("late_scanin", n_scanin - s_scanin, 0);

        // Back-to-back pulses hold lcnt at 0
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            check("b2b_swap", int'(swap_start), 1);
        end
        check("b2b_locked", int'(locked), 0);
        tick(1'b0);
        check("b2b_swap_tail", int'(swap_start), 1);
        tick(1'b0);
        check("b2b_swap_end", int'(swap_start), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
